pwm_multi_ctrl: RTL

Parametrised multi-channel PWM generator with per-channel debounced increment/decrement buttons. It generalises the single-channel 10-step PWM block in four ways: configurable channel count, period and step; saturating duty arithmetic; glitch-free duty updates applied only at period boundaries; and a runtime-selectable edge- or center-aligned mode. It sits behind the top-level pad wrapper, which routes button pins to `inc`/`dec` and drives `pwm_out` onto output pads.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_btn_debounce.sv | 36 +++
 rtl/pwm_multi_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller:
// mode encodings and the saturating duty step helper.
package pwm_pkg;

    localparam logic PWM_EDGE   = 1'b0;
    localparam logic PWM_CENTER = 1'b1;

    // Moves val by step toward period (up) or toward 0 (down), clamped.
    // Operands are far wider than any duty register, so nothing wraps.
    function automatic logic [31:0] pwm_sat(
        input logic [31:0] val,
        input logic [31:0] step,
        input logic        up,
        input logic [31:0] period
    );
        logic [31:0] res;
        res = '0;
        if (up) begin
            res = val + step;
            if (res > period) begin
                res = period;
            end
        end else if (val >= step) begin
            res = val - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Two-stage tick-sampled button synchroniser with rising-edge press pulse.
// Ports: clk, rst_n (async low), tick (sample strobe), btn (raw), press (1-cycle).
module pwm_btn_debounce (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic press
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (tick) begin
            s1_d = btn;
            s2_d = s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Qualified by tick so a press lasts exactly one clk cycle.
    assign press = tick & s1_q & ~s2_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator, edge/center aligned, with debounced inc/dec.
// Ports: clk, rst_n, ena, inc[CH], dec[CH], mode -> pwm_out[CH],
//        duty_o[CH*CNT_W] (active duty per channel), period_start.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int CH        = 2,
    parameter int CNT_W     = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 5,
    parameter int DEB_DIV   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [CH-1:0]         inc,
    input  logic [CH-1:0]         dec,
    input  logic                  mode,
    output logic [CH-1:0]         pwm_out,
    output logic [CH*CNT_W-1:0]   duty_o,
    output logic                  period_start
);

    localparam int DIV_W = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEB_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   PER_X    = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_INIT);

    // Shared debounce tick divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        div_d = div_q;
        if (ena) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign tick = ena & (div_q == '0);

    // Shared period counter; dir_q=1 means counting down (center mode only)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             mact_q, mact_d;
    logic             bnd;
    logic             ps_q, ps_d;

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mact_d = mact_q;
        bnd    = 1'b0;
        if (ena) begin
            if (mact_q == PWM_EDGE) begin
                if (cnt_q == CNT_LAST) begin
                    bnd = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (!dir_q) begin
                // top value is held for one cycle while turning around
                if (cnt_q == CNT_LAST) begin
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    bnd = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            if (bnd) begin
                cnt_d  = '0;
                dir_d  = 1'b0;
                mact_d = mode;
            end
        end
    end

    // cnt=0 counting up only happens in the first cycle of a period
    assign ps_d = ena & (cnt_q == '0) & ~dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            mact_q <= PWM_EDGE;
            ps_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            mact_q <= mact_d;
            ps_q   <= ps_d;
        end
    end

    assign period_start = ps_q;

    // Per-channel buttons, duty registers and compare
    for (genvar i = 0; i < CH; i++) begin : g_ch

        logic             inc_p;
        logic             dec_p;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic [CNT_W-1:0] act_q, act_d;
        logic [CNT_W:0]   thr;
        logic             pwm_q, pwm_d;

        pwm_btn_debounce u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (inc[i]),
            .press (inc_p)
        );

        pwm_btn_debounce u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (dec[i]),
            .press (dec_p)
        );

        always_comb begin
            shd_d = shd_q;
            // simultaneous inc and dec cancel out
            if (inc_p ^ dec_p) begin
                shd_d = CNT_W'(pwm_sat(32'(shd_q), 32'(STEP),
                                       inc_p, 32'(PERIOD)));
            end
        end

        // shadow is only taken over at a period boundary
        assign act_d = bnd ? shd_q : act_q;

        assign thr = PER_X - {1'b0, act_q};

        always_comb begin
            pwm_d = 1'b0;
            if (ena) begin
                if (mact_q == PWM_CENTER) begin
                    pwm_d = ({1'b0, cnt_q} >= thr);
                end else begin
                    pwm_d = (cnt_q < act_q);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shd_q <= DUTY_RST;
                act_q <= DUTY_RST;
                pwm_q <= 1'b0;
            end else begin
                shd_q <= shd_d;
                act_q <= act_d;
                pwm_q <= pwm_d;
            end
        end

        assign pwm_out[i]                  = pwm_q;
        assign duty_o[i*CNT_W +: CNT_W]    = act_q;

    end

endmodule
